// File: rtl/alb_scoreboard.sv
// Self-checking stage behind the ALB and its reference model: compares result
// vectors, counts checks/mismatches, captures the first failure, reports done/pass.
module alb_scoreboard #(
    parameter int DATA_WIDTH  = 11,
    parameter int CNT_WIDTH   = 16,
    parameter int SKIP_CYCLES = 2,
    parameter int NUM_CHECKS  = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] f_alb,
    input  logic                  co_alb,
    input  logic                  vo_alb,
    input  logic                  no_alb,
    input  logic                  zo_alb,
    input  logic [DATA_WIDTH-1:0] f_ref,
    input  logic                  co_ref,
    input  logic                  vo_ref,
    input  logic                  no_ref,
    input  logic                  zo_ref,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  check_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  first_err_valid,
    output logic [CNT_WIDTH-1:0]  first_err_index,
    output logic [DATA_WIDTH-1:0] first_err_f_alb,
    output logic [DATA_WIDTH-1:0] first_err_f_ref,
    output logic [7:0]            first_err_flags,
    output logic                  done,
    output logic                  pass
);

    localparam int SKIP_W = $clog2(SKIP_CYCLES + 2);
    // SKIP_CYCLES of 0 and 1 both spend exactly one edge in WARMUP.
    localparam logic [SKIP_W-1:0] SKIP_LAST =
        (SKIP_CYCLES == 0) ? '0 : SKIP_W'(SKIP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0] CHECK_TARGET = CNT_WIDTH'(NUM_CHECKS);
    localparam bit                   BOUNDED      = (NUM_CHECKS != 0);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [SKIP_W-1:0]     skip_cnt;
    logic [DATA_WIDTH+3:0] vec_alb;
    logic [DATA_WIDTH+3:0] vec_ref;
    logic                  sample_bad;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [CNT_WIDTH-1:0]  err_next;
    logic                  last_check;

    always_comb begin
        vec_alb    = {f_alb, co_alb, vo_alb, no_alb, zo_alb};
        vec_ref    = {f_ref, co_ref, vo_ref, no_ref, zo_ref};
        // Case inequality so unknowns on either side are flagged as failures.
        sample_bad = (vec_alb !== vec_ref);
        count_next = check_count + 1'b1;
        err_next   = (err_count == CNT_MAX) ? err_count : err_count + 1'b1;
        last_check = BOUNDED && (count_next == CHECK_TARGET);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= WARMUP;
            skip_cnt        <= '0;
            mismatch        <= 1'b0;
            check_count     <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
            first_err_f_alb <= '0;
            first_err_f_ref <= '0;
            first_err_flags <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else if (clear) begin
            state           <= WARMUP;
            skip_cnt        <= '0;
            mismatch        <= 1'b0;
            check_count     <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
            first_err_f_alb <= '0;
            first_err_f_ref <= '0;
            first_err_flags <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                WARMUP: begin
                    if (skip_cnt == SKIP_LAST) state <= RUN;
                    else                       skip_cnt <= skip_cnt + 1'b1;
                end
                RUN: begin
                    if (en) begin
                        check_count <= count_next;
                        mismatch    <= sample_bad;
                        if (sample_bad) begin
                            err_count <= err_next;
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_index <= check_count;
                                first_err_f_alb <= f_alb;
                                first_err_f_ref <= f_ref;
                                first_err_flags <= {co_alb, vo_alb, no_alb, zo_alb,
                                                    co_ref, vo_ref, no_ref, zo_ref};
                            end
                        end
                        if (last_check) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= !sample_bad && (err_count == '0);
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= WARMUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alb_scoreboard.sv
// Scoreboard bench: four differently-parameterised scoreboards share one random
// stimulus stream; a behavioural model predicts every cycle's outputs.
module tb_alb_scoreboard;

    localparam int NI = 4;
    localparam int DW = 11;
    localparam int CWS   [NI] = '{16, 16, 4, 16};
    localparam int SKIPS [NI] = '{2, 2, 2, 0};
    localparam int NCS   [NI] = '{4, 8, 0, 3};

    typedef struct packed {
        logic          mis;
        logic [15:0]   cnt;
        logic [15:0]   err;
        logic          fev;
        logic [15:0]   fidx;
        logic [DW-1:0] fa;
        logic [DW-1:0] fr;
        logic [7:0]    fl;
        logic          done;
        logic          pass;
    } snap_t;

    typedef struct packed {
        int              cyc;
        snap_t [NI-1:0]  s;
    } exp_t;

    typedef struct {
        int            warm;
        int            cnt;
        int            err;
        bit            fev;
        int            fidx;
        logic [DW-1:0] fa;
        logic [DW-1:0] fr;
        logic [7:0]    fl;
        bit            done;
        bit            pass;
        bit            mis;
    } model_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic en = 1'b0;
    logic [DW-1:0] f_alb = '0, f_ref = '0;
    logic co_alb = 0, vo_alb = 0, no_alb = 0, zo_alb = 0;
    logic co_ref = 0, vo_ref = 0, no_ref = 0, zo_ref = 0;

    snap_t  act [NI];
    model_t m [NI];
    exp_t   q [$];
    int     cyc = 0;
    int     checks = 0;
    int     passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CW = CWS[g];
        logic          mis, fev, dn, ps;
        logic [CW-1:0] cc, ec, fi;
        logic [DW-1:0] fa, fr;
        logic [7:0]    fl;
        alb_scoreboard #(
            .DATA_WIDTH(DW), .CNT_WIDTH(CW),
            .SKIP_CYCLES(SKIPS[g]), .NUM_CHECKS(NCS[g])
        ) u_dut (
            .clk(clk), .reset(reset), .clear(clear), .en(en),
            .f_alb(f_alb), .co_alb(co_alb), .vo_alb(vo_alb), .no_alb(no_alb), .zo_alb(zo_alb),
            .f_ref(f_ref), .co_ref(co_ref), .vo_ref(vo_ref), .no_ref(no_ref), .zo_ref(zo_ref),
            .mismatch(mis), .check_count(cc), .err_count(ec),
            .first_err_valid(fev), .first_err_index(fi),
            .first_err_f_alb(fa), .first_err_f_ref(fr), .first_err_flags(fl),
            .done(dn), .pass(ps)
        );
        assign act[g] = {mis, 16'(cc), 16'(ec), fev, 16'(fi), fa, fr, fl, dn, ps};
    end

    // Reference behaviour: warm-up edges, then count enabled compares until the target.
    task automatic model_step(input int i, input bit r, input bit c, input bit e,
                              input logic [DW+3:0] va, input logic [DW+3:0] vr);
        int cmax;
        bit bad;
        cmax = (1 << CWS[i]) - 1;
        if (r || c) begin
            m[i].warm = (SKIPS[i] == 0) ? 1 : SKIPS[i];
            m[i].cnt = 0; m[i].err = 0; m[i].fev = 0; m[i].fidx = 0;
            m[i].fa = '0; m[i].fr = '0; m[i].fl = '0;
            m[i].done = 0; m[i].pass = 0; m[i].mis = 0;
        end else begin
            m[i].mis = 0;
            if (m[i].warm > 0) begin
                m[i].warm--;
            end else if (!m[i].done && e) begin
                bad = (va !== vr);
                if (bad && !m[i].fev) begin
                    m[i].fev  = 1;
                    m[i].fidx = m[i].cnt;
                    m[i].fa   = va[DW+3:4];
                    m[i].fr   = vr[DW+3:4];
                    m[i].fl   = {va[3:0], vr[3:0]};
                end
                m[i].cnt = (m[i].cnt + 1) & cmax;
                if (bad) begin
                    m[i].mis = 1;
                    if (m[i].err < cmax) m[i].err++;
                end
                if (NCS[i] != 0 && m[i].cnt == NCS[i]) begin
                    m[i].done = 1;
                    m[i].pass = (m[i].err == 0);
                end
            end
        end
    endtask

    function automatic snap_t to_snap(input int i);
        return {m[i].mis, 16'(m[i].cnt), 16'(m[i].err), m[i].fev, 16'(m[i].fidx),
                m[i].fa, m[i].fr, m[i].fl, m[i].done, m[i].pass};
    endfunction

    // Drive one cycle's inputs just after the falling edge and queue the prediction.
    task automatic step(input bit r, input bit c, input bit e,
                        input logic [DW+3:0] va, input logic [DW+3:0] vr);
        exp_t x;
        bit   rise;
        @(negedge clk);
        #1;
        rise  = r && !reset;
        reset = r; clear = c; en = e;
        {f_alb, co_alb, vo_alb, no_alb, zo_alb} = va;
        {f_ref, co_ref, vo_ref, no_ref, zo_ref} = vr;
        x.cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            model_step(i, r, c, e, va, vr);
            x.s[i] = to_snap(i);
        end
        q.push_back(x);
        if (rise) begin
            #1;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (act[i] === '0) passes++;
                else $display("FAIL async_reset inst%0d actual=%h required=0", i, act[i]);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (x.cyc == cyc && act[i] === x.s[i]) passes++;
                else $display("FAIL snap inst%0d cyc%0d actual=%h required=%h",
                              i, cyc, act[i], x.s[i]);
            end
        end
    end

    function automatic logic [DW+3:0] rnd();
        return (DW + 4)'($urandom);
    endfunction

    task automatic same(input bit e);
        logic [DW+3:0] v;
        v = rnd();
        step(0, 0, e, v, v);
    endtask

    task automatic restart();
        step(0, 1, 1, rnd(), rnd());
        same(1);
        same(1);
    endtask

    initial begin
        logic [DW+3:0] b;
        logic [3:0]    fl;
        step(1, 0, 0, '0, '0);
        step(1, 0, 1, rnd(), rnd());
        for (int j = 0; j < 14; j++) same(1);

        // Result mismatch on compare index 2 only.
        restart();
        for (int j = 0; j < 10; j++) begin
            fl = 4'($urandom);
            if (j == 2) step(0, 0, 1, {11'h155, fl}, {11'h154, fl});
            else        same(1);
        end

        // Carry mismatch at index 1, zero-flag mismatch at index 4.
        restart();
        for (int j = 0; j < 10; j++) begin
            b = rnd();
            if (j == 1)      step(0, 0, 1, b, b ^ 15'h8);
            else if (j == 4) step(0, 0, 1, b, b ^ 15'h1);
            else             step(0, 0, 1, b, b);
        end

        // Continuous mismatch: saturation and wrap on the narrow-counter instance.
        restart();
        for (int j = 0; j < 20; j++) begin
            b = rnd();
            step(0, 0, 1, b, ~b);
        end

        // en toggling with mismatching data offered only while en is low.
        restart();
        for (int j = 0; j < 8; j++) begin
            b = rnd();
            if (j % 2 == 0) step(0, 0, 1, b, b);
            else            step(0, 0, 0, b, ~b);
        end

        // Reset mid-run, then a clear while done.
        restart();
        for (int j = 0; j < 5; j++) begin
            b = rnd();
            step(0, 0, 1, b, (j == 1) ? ~b : b);
        end
        step(1, 0, 1, rnd(), rnd());
        for (int j = 0; j < 10; j++) same(1);
        step(0, 1, 0, rnd(), rnd());
        for (int j = 0; j < 6; j++) same(1);

        // Randomised traffic with occasional clears and resets.
        for (int j = 0; j < 400; j++) begin
            b = rnd();
            step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 7, b,
                 ($urandom_range(0, 4) == 0) ? b ^ (15'(1) << $urandom_range(0, 14)) : b);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain actual=%0d required=0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
